// File: rtl/mem_access_unit.sv
// MEM stage: data-memory req/ack access with pipeline stall, branch resolve, MEM/WB register.
// Optional alignment check enabled by defining MEM_ALIGN_CHK_EN.
module mem_access_unit #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_Branch,
  input  logic        MEM_BNE,
  input  logic        MEM_zero,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_Mem2R,
  input  logic        MEM_RegWrite,
  input  logic        MEM_jal,
  input  logic [31:0] MEM_AluRes,
  input  logic [31:0] MEM_GPR_Data_2,
  input  logic [4:0]  MEM_Wesel,
  input  logic [31:0] MEM_NPC,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mem_stall,
  output logic        MEM_PCSrc,
  output logic        dm_err,
  output logic        WB_RegWrite,
  output logic        WB_Mem2R,
  output logic        WB_jal,
  output logic [31:0] WB_MemData,
  output logic [31:0] WB_AluRes,
  output logic [31:0] WB_NPC,
  output logic [4:0]  WB_Wesel
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_q;
  logic             mem_op;
  logic             misalign;
  logic             timeout;
  logic             req_int;
  logic             stall_int;

  assign mem_op  = MEM_MemRead | MEM_MemWrite;
  assign timeout = (cnt == CNT_LAST);

`ifdef MEM_ALIGN_CHK_EN
  assign misalign = (MEM_AluRes[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign MEM_PCSrc = (MEM_Branch & MEM_zero) | (MEM_BNE & ~MEM_zero);

  assign dm_addr  = MEM_AluRes;
  assign dm_wdata = MEM_GPR_Data_2;

  // Gated by rst so the bus sees the request drop while reset is still asserted.
  assign dm_req    = req_int & ~rst;
  assign mem_stall = stall_int & ~rst;
  assign dm_we     = MEM_MemWrite & ~rst;

  always_comb begin
    state_nxt = state;
    req_int   = 1'b0;
    stall_int = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          stall_int = 1'b1;
          if (misalign) begin
            state_nxt = S_DONE;
          end else begin
            req_int   = 1'b1;
            state_nxt = dm_ack ? S_DONE : S_BUSY;
          end
        end
      end
      S_BUSY: begin
        req_int   = 1'b1;
        stall_int = 1'b1;
        if (dm_ack || timeout) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      dm_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            if (misalign) begin
              rdata_q <= '0;
              dm_err  <= 1'b1;
            end else if (dm_ack) begin
              rdata_q <= dm_rdata;
            end else begin
              cnt <= '0;
            end
          end
        end
        S_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          // Ack takes priority over a simultaneous timeout.
          if (dm_ack) begin
            rdata_q <= dm_rdata;
          end else if (timeout) begin
            rdata_q <= '0;
            dm_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_RegWrite <= 1'b0;
      WB_Mem2R    <= 1'b0;
      WB_jal      <= 1'b0;
      WB_MemData  <= '0;
      WB_AluRes   <= '0;
      WB_NPC      <= '0;
      WB_Wesel    <= '0;
    end else if (mem_stall) begin
      WB_RegWrite <= 1'b0;
      WB_Mem2R    <= 1'b0;
      WB_jal      <= 1'b0;
    end else begin
      WB_RegWrite <= MEM_RegWrite;
      WB_Mem2R    <= MEM_Mem2R;
      WB_jal      <= MEM_jal;
      WB_MemData  <= (state == S_DONE) ? rdata_q : dm_rdata;
      WB_AluRes   <= MEM_AluRes;
      WB_NPC      <= MEM_NPC;
      WB_Wesel    <= MEM_Wesel;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level model (stall count per access).
module tb_mem_access_unit;

  localparam int unsigned WL = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_Branch, MEM_BNE, MEM_zero, MEM_MemRead, MEM_MemWrite;
  logic        MEM_Mem2R, MEM_RegWrite, MEM_jal;
  logic [31:0] MEM_AluRes, MEM_GPR_Data_2, MEM_NPC;
  logic [4:0]  MEM_Wesel;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_stall, MEM_PCSrc, dm_err;
  logic        WB_RegWrite, WB_Mem2R, WB_jal;
  logic [31:0] WB_MemData, WB_AluRes, WB_NPC;
  logic [4:0]  WB_Wesel;

  always #5 clk = ~clk;

  mem_access_unit #(.WAIT_LIMIT(WL), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .MEM_Branch(MEM_Branch), .MEM_BNE(MEM_BNE), .MEM_zero(MEM_zero),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_Mem2R(MEM_Mem2R), .MEM_RegWrite(MEM_RegWrite), .MEM_jal(MEM_jal),
    .MEM_AluRes(MEM_AluRes), .MEM_GPR_Data_2(MEM_GPR_Data_2),
    .MEM_Wesel(MEM_Wesel), .MEM_NPC(MEM_NPC),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_stall(mem_stall), .MEM_PCSrc(MEM_PCSrc), .dm_err(dm_err),
    .WB_RegWrite(WB_RegWrite), .WB_Mem2R(WB_Mem2R), .WB_jal(WB_jal),
    .WB_MemData(WB_MemData), .WB_AluRes(WB_AluRes), .WB_NPC(WB_NPC),
    .WB_Wesel(WB_Wesel)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        err_exp;
  logic [31:0] wb_alu_exp, wb_npc_exp, wb_md_exp;
  logic [4:0]  wb_wesel_exp;
  logic        fix_rdata_en;
  logic [31:0] fix_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a request is held for (ack delay + 1) stalled cycles, capped at WL+1 on timeout,
  // followed by one unstalled cycle after which MEM/WB carries the instruction.
  task automatic run_instr(input logic rd, input logic wr, input logic m2r, input logic rw,
                           input logic jal, input logic br, input logic bne, input logic zero,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] npc, input logic [4:0] wesel,
                           input int unsigned ack_dly);
    logic        mem_op, mis, to, pcsrc;
    int unsigned n_stall;
    logic [31:0] cap;
    mem_op = rd | wr;
    mis    = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
    mis = mem_op && (addr[1:0] != 2'b00);
`endif
    to    = mem_op && !mis && (ack_dly > WL);
    pcsrc = (br && zero) || (bne && !zero);
    if (!mem_op)  n_stall = 0;
    else if (mis) n_stall = 1;
    else if (to)  n_stall = WL + 1;
    else          n_stall = ack_dly + 1;

    MEM_MemRead = rd;  MEM_MemWrite = wr; MEM_Mem2R = m2r; MEM_RegWrite = rw;
    MEM_jal = jal;     MEM_Branch = br;   MEM_BNE = bne;   MEM_zero = zero;
    MEM_AluRes = addr; MEM_GPR_Data_2 = wdata; MEM_NPC = npc; MEM_Wesel = wesel;
    cap = '0;

    for (int unsigned c = 0; c < n_stall; c++) begin
      dm_rdata = fix_rdata_en ? fix_rdata : $urandom;
      dm_ack   = !mis && (c == ack_dly);
      @(negedge clk);
      check_eq("stall_hold", 32'(mem_stall), 32'd1);
      check_eq("req_hold", 32'(dm_req), 32'(!mis));
      check_eq("we", 32'(dm_we), 32'(wr));
      check_eq("addr", dm_addr, addr);
      check_eq("wdata", dm_wdata, wdata);
      check_eq("pcsrc_stall", 32'(MEM_PCSrc), 32'(pcsrc));
      if (dm_ack) cap = dm_rdata;
      @(posedge clk); #1;
      check_eq("bubble_rw", 32'(WB_RegWrite), 32'd0);
      check_eq("bubble_alu_keep", WB_AluRes, wb_alu_exp);
    end
    if (to || mis) err_exp = 1'b1;

    dm_ack   = mem_op ? 1'b0 : 1'($urandom_range(0, 1));
    dm_rdata = fix_rdata_en ? fix_rdata : $urandom;
    @(negedge clk);
    check_eq("stall_free", 32'(mem_stall), 32'd0);
    check_eq("req_free", 32'(dm_req), 32'd0);
    check_eq("pcsrc", 32'(MEM_PCSrc), 32'(pcsrc));
    if (!mem_op) cap = dm_rdata;
    @(posedge clk); #1;
    wb_alu_exp = addr; wb_npc_exp = npc; wb_md_exp = cap; wb_wesel_exp = wesel;
    check_eq("wb_rw", 32'(WB_RegWrite), 32'(rw));
    check_eq("wb_m2r", 32'(WB_Mem2R), 32'(m2r));
    check_eq("wb_jal", 32'(WB_jal), 32'(jal));
    check_eq("wb_memdata", WB_MemData, wb_md_exp);
    check_eq("wb_alu", WB_AluRes, wb_alu_exp);
    check_eq("wb_npc", WB_NPC, wb_npc_exp);
    check_eq("wb_wesel", 32'(WB_Wesel), 32'(wb_wesel_exp));
    check_eq("dm_err", 32'(dm_err), 32'(err_exp));
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req", 32'(dm_req), 32'd0);
    check_eq("rst_stall", 32'(mem_stall), 32'd0);
    check_eq("rst_we", 32'(dm_we), 32'd0);
    check_eq("rst_err", 32'(dm_err), 32'd0);
    check_eq("rst_wb_rw", 32'(WB_RegWrite), 32'd0);
    check_eq("rst_wb_m2r", 32'(WB_Mem2R), 32'd0);
    check_eq("rst_wb_jal", 32'(WB_jal), 32'd0);
    check_eq("rst_wb_md", WB_MemData, 32'd0);
    check_eq("rst_wb_alu", WB_AluRes, 32'd0);
    check_eq("rst_wb_npc", WB_NPC, 32'd0);
    check_eq("rst_wb_wesel", 32'(WB_Wesel), 32'd0);
  endtask

  task automatic model_reset();
    err_exp = 1'b0; wb_alu_exp = '0; wb_npc_exp = '0; wb_md_exp = '0; wb_wesel_exp = '0;
  endtask

  initial begin
    rst = 1'b1;
    MEM_Branch = 0; MEM_BNE = 0; MEM_zero = 0; MEM_MemRead = 0; MEM_MemWrite = 0;
    MEM_Mem2R = 0; MEM_RegWrite = 0; MEM_jal = 0;
    MEM_AluRes = '0; MEM_GPR_Data_2 = '0; MEM_NPC = '0; MEM_Wesel = '0;
    dm_rdata = '0; dm_ack = 0;
    fix_rdata_en = 1'b0; fix_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait load.
    fix_rdata_en = 1'b1; fix_rdata = 32'hDEADBEEF;
    run_instr(1, 0, 1, 1, 0, 0, 0, 0, 32'h10, 32'h0, 32'h104, 5'd5, 0);
    fix_rdata_en = 1'b0;
    // Store with three wait cycles.
    run_instr(0, 1, 0, 0, 0, 0, 0, 0, 32'h20, 32'h12345678, 32'h108, 5'd0, 3);
    // Ack on the last permitted cycle still wins over the timeout.
    run_instr(1, 0, 1, 1, 0, 0, 0, 0, 32'h24, 32'h0, 32'h10C, 5'd7, WL);
    // Timeout: no ack ever.
    run_instr(1, 0, 1, 1, 0, 0, 0, 0, 32'h30, 32'h0, 32'h110, 5'd9, 1000);
    // Branch resolution.
    run_instr(0, 0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0, 32'h114, 5'd0, 0);
    run_instr(0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h118, 5'd0, 0);
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h11C, 5'd0, 0);
`ifdef MEM_ALIGN_CHK_EN
    run_instr(1, 0, 1, 1, 0, 0, 0, 0, 32'h22, 32'h0, 32'h120, 5'd3, 0);
`endif

    for (int i = 0; i < 80; i++) begin
      int unsigned kind, dly;
      kind = $urandom_range(0, 3);
      dly  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 5) : $urandom_range(WL - 1, WL + 2);
      run_instr(kind[0], kind[1], 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom),
                $urandom, $urandom, $urandom, 5'($urandom), dly);
    end

    // Reset in the middle of a waiting load.
    MEM_MemRead = 1; MEM_MemWrite = 1; MEM_RegWrite = 1; MEM_Mem2R = 1;
    MEM_AluRes = 32'h40; MEM_Branch = 0; MEM_BNE = 0;
    dm_ack = 0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs();
    MEM_MemRead = 0; MEM_MemWrite = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_instr(0, 0, 0, 1, 1, 0, 0, 0, 32'h50, 32'h0, 32'h200, 5'd12, 0);
    run_instr(1, 0, 1, 1, 0, 0, 0, 0, 32'h54, 32'h0, 32'h204, 5'd13, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
